// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier controller.
// Contents: FSM state enum (3-bit encoding), state count, bit-counter width helper.
package mult_ctrl_pkg;

   localparam int unsigned NUM_STATES = 5;
   localparam int unsigned STATE_W    = $clog2(NUM_STATES);

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_ADD   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_DONE  = 3'd4
   } mult_state_t;

   // Counter must hold values 0..WIDTH-1; sized with one spare code for safety
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mult_seq_control_bit_counter.sv
// Bit-index counter for the multiplier sequencer.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset (count -> 0)
//   i_clr    synchronous clear (count -> 0)
//   i_inc    advance to next bit (holds at WIDTH-1, never wraps)
//   o_tc     terminal count, high when count == WIDTH-1
module mult_seq_control_bit_counter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] r_count;

   assign o_tc = (r_count == LAST);

   // Saturating at the last bit keeps the index in range even if inc is held
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_count <= '0;
      end else if (i_inc && !o_tc) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mult_seq_control.sv
// Controller for a WIDTH-bit signed shift-add multiplier datapath (X:A:B).
// Sequences clear, add/subtract and arithmetic-shift phases using a bit counter.
// Optional macro MULT_SKIP_ZERO_EN: zero multiplier bits shift in the ADD cycle,
// skipping the separate SHIFT state.
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_execute                   start request (level), one multiply per high level
//   i_load_a, i_load_b          register load requests (honoured in IDLE only)
//   i_m                         current multiplier LSB B[0]
//   o_ld_a, o_ld_b              register A/B load enables
//   o_clr_xa                    clear X and A before a run
//   o_add_en, o_sub_en          latch A+S / A-S into X:A
//   o_shift_en                  arithmetic shift right of X:A:B
//   o_busy, o_done              run in progress / result ready
// All outputs are combinational from state, bit counter and i_m.
module mult_seq_control
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_execute,
   input  logic i_load_a,
   input  logic i_load_b,
   input  logic i_m,
   output logic o_ld_a,
   output logic o_ld_b,
   output logic o_clr_xa,
   output logic o_add_en,
   output logic o_sub_en,
   output logic o_shift_en,
   output logic o_busy,
   output logic o_done
);

   mult_state_t r_state;
   mult_state_t w_next;
   logic        w_cnt_clr;
   logic        w_cnt_inc;
   logic        w_last_bit;

   mult_seq_control_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_cnt_clr),
      .i_inc   (w_cnt_inc),
      .o_tc    (w_last_bit)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_next     = r_state;
      w_cnt_clr  = 1'b0;
      w_cnt_inc  = 1'b0;
      o_ld_a     = 1'b0;
      o_ld_b     = 1'b0;
      o_clr_xa   = 1'b0;
      o_add_en   = 1'b0;
      o_sub_en   = 1'b0;
      o_shift_en = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            o_ld_a = i_load_a;
            o_ld_b = i_load_b;
            if (i_execute) begin
               w_next = ST_CLR;
            end
         end

         ST_CLR: begin
            o_clr_xa  = 1'b1;
            o_busy    = 1'b1;
            w_cnt_clr = 1'b1;
            w_next    = ST_ADD;
         end

         ST_ADD: begin
            o_busy = 1'b1;
            if (i_m) begin
               // Sign bit of a two's-complement multiplier has negative weight
               if (w_last_bit) begin
                  o_sub_en = 1'b1;
               end else begin
                  o_add_en = 1'b1;
               end
               w_next = ST_SHIFT;
            end else begin
`ifdef MULT_SKIP_ZERO_EN
               // Nothing to accumulate: shift now and stay on the fast path
               o_shift_en = 1'b1;
               if (w_last_bit) begin
                  w_next = ST_DONE;
               end else begin
                  w_cnt_inc = 1'b1;
                  w_next    = ST_ADD;
               end
`else
               w_next = ST_SHIFT;
`endif
            end
         end

         ST_SHIFT: begin
            o_shift_en = 1'b1;
            o_busy     = 1'b1;
            if (w_last_bit) begin
               w_next = ST_DONE;
            end else begin
               w_cnt_inc = 1'b1;
               w_next    = ST_ADD;
            end
         end

         ST_DONE: begin
            o_done = 1'b1;
            // Holding Execute must not retrigger a second run
            if (!i_execute) begin
               w_next = ST_IDLE;
            end
         end

         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench for mult_seq_control: an 8-bit and a 16-bit instance,
// each with a small B-register model supplying M. Directed vector table plus
// hand sequences for reset, load gating and mid-run abort.
module tb_mult_seq_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset   = 1'b1;
   logic        execute = 1'b0;
   logic        load_a  = 1'b0;
   logic        load_b  = 1'b0;
   bit          sel     = 1'b0;
   logic [15:0] operand = '0;

   logic [7:0]  b8  = '0;
   logic [15:0] b16 = '0;

   logic ld_a8, ld_b8, clr8, add8, sub8, sh8, busy8, done8;
   logic ld_a16, ld_b16, clr16, add16, sub16, sh16, busy16, done16;
   logic ld_a, ld_b, clr_xa, add_en, sub_en, shift_en, busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   mult_seq_control #(.WIDTH(8)) dut8 (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_execute  (execute & ~sel),
      .i_load_a   (load_a & ~sel),
      .i_load_b   (load_b & ~sel),
      .i_m        (b8[0]),
      .o_ld_a     (ld_a8),
      .o_ld_b     (ld_b8),
      .o_clr_xa   (clr8),
      .o_add_en   (add8),
      .o_sub_en   (sub8),
      .o_shift_en (sh8),
      .o_busy     (busy8),
      .o_done     (done8)
   );

   mult_seq_control #(.WIDTH(16)) dut16 (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_execute  (execute & sel),
      .i_load_a   (load_a & sel),
      .i_load_b   (load_b & sel),
      .i_m        (b16[0]),
      .o_ld_a     (ld_a16),
      .o_ld_b     (ld_b16),
      .o_clr_xa   (clr16),
      .o_add_en   (add16),
      .o_sub_en   (sub16),
      .o_shift_en (sh16),
      .o_busy     (busy16),
      .o_done     (done16)
   );

   // Multiplier register models: load in IDLE, shift right on Shift_En
   always @(posedge clk) begin
      if (ld_b8)    b8 <= operand[7:0];
      else if (sh8) b8 <= b8 >> 1;
      if (ld_b16)    b16 <= operand;
      else if (sh16) b16 <= b16 >> 1;
   end

   always_comb begin
      if (sel) begin
         ld_a = ld_a16; ld_b = ld_b16; clr_xa = clr16; add_en = add16;
         sub_en = sub16; shift_en = sh16; busy = busy16; done = done16;
      end else begin
         ld_a = ld_a8; ld_b = ld_b8; clr_xa = clr8; add_en = add8;
         sub_en = sub8; shift_en = sh8; busy = busy8; done = done8;
      end
   end

   typedef struct {
      logic [15:0] b;
      bit          wide;
      int          busy_fix;
      int          busy_skip;
      logic [15:0] add_mask;
      int          sub_cnt;
      int          sub_pos;
      int          shifts;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int          busy_n = 0, clr_n = 0, shift_n = 0, sub_n = 0, sub_pos = -1;
      int          bit_idx = 0, ovl = 0, ld_run = 0, done_n = 0, rerun = 0;
      logic [15:0] add_m = '0;
      bit          seen_done = 1'b0;
      int          exp_busy;
`ifdef MULT_SKIP_ZERO_EN
      exp_busy = v.busy_skip;
`else
      exp_busy = v.busy_fix;
`endif
      sel = v.wide;
      // Load cycle in IDLE
      advance();
      operand = v.b; load_a = 1'b1; load_b = 1'b1; execute = 1'b0;
      @(negedge clk);
      chk("idle_ld_a", int'(ld_a), 1);
      chk("idle_ld_b", int'(ld_b), 1);
      // Execute raised, LoadA held high through the run
      advance();
      load_b = 1'b0; execute = 1'b1;
      @(negedge clk);
      chk("idle_not_busy", int'(busy), 0);
      for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
         advance();
         @(negedge clk);
         if (busy) busy_n++;
         if (clr_xa) clr_n++;
         if (add_en && bit_idx < 16) add_m[bit_idx] = 1'b1;
         if (sub_en) begin sub_n++; sub_pos = bit_idx; end
         if ((add_en && sub_en) || ((add_en || sub_en) && shift_en)) ovl++;
         if (ld_a || ld_b) ld_run++;
         if (shift_en) begin shift_n++; bit_idx++; end
         if (done) seen_done = 1'b1;
      end
      chk("reached_done", int'(seen_done), 1);
      // Execute held across DONE
      for (int k = 0; k < 10; k++) begin
         advance();
         @(negedge clk);
         if (done) done_n++;
         if (busy || clr_xa) rerun++;
         if (ld_a || ld_b) ld_run++;
      end
      chk("busy_cycles", busy_n, exp_busy);
      chk("clr_pulses", clr_n, 1);
      chk("add_mask", int'(add_m), int'(v.add_mask));
      chk("sub_count", sub_n, v.sub_cnt);
      chk("sub_bit", sub_pos, v.sub_pos);
      chk("shift_pulses", shift_n, v.shifts);
      chk("enable_overlap", ovl, 0);
      chk("load_outside_idle", ld_run, 0);
      chk("done_held", done_n, 10);
      chk("no_retrigger", rerun, 0);
      // Drop Execute: one cycle still in DONE, then IDLE
      advance();
      execute = 1'b0; load_a = 1'b0;
      @(negedge clk);
      advance();
      @(negedge clk);
      chk("idle_done_low", int'(done), 0);
      chk("idle_busy_low", int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{16'h0055, 1'b0, 17, 13, 16'h0055, 0, -1, 8};
      vecs[1] = '{16'h0080, 1'b0, 17, 10, 16'h0000, 1,  7, 8};
      vecs[2] = '{16'h0000, 1'b0, 17,  9, 16'h0000, 0, -1, 8};
      vecs[3] = '{16'h00FF, 1'b0, 17, 17, 16'h007F, 1,  7, 8};
      vecs[4] = '{16'h0001, 1'b1, 33, 18, 16'h0001, 0, -1, 16};
      vecs[5] = '{16'h8001, 1'b1, 33, 19, 16'h0001, 1, 15, 16};

      // Reset state
      reset = 1'b1; load_a = 1'b1; load_b = 1'b0; execute = 1'b0; sel = 1'b0;
      advance();
      advance();
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_clr", int'(clr_xa), 0);
      chk("rst_arith", int'(add_en | sub_en | shift_en), 0);
      chk("rst_ld_a_follows", int'(ld_a), 1);
      chk("rst_ld_b_follows", int'(ld_b), 0);
      chk("rst_wide_busy", int'(busy16), 0);
      advance();
      reset = 1'b0; load_a = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Abort a run on the 5th cycle after Execute
      sel = 1'b0;
      advance();
      operand = 16'h00FF; load_b = 1'b1;
      advance();
      load_b = 1'b0; execute = 1'b1;
      for (int k = 0; k < 5; k++) advance();
      reset = 1'b1; execute = 1'b0;
      @(negedge clk);
      chk("abort_busy_before", int'(busy), 1);
      advance();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_shift", int'(shift_en), 0);
      chk("abort_done", int'(done), 0);
      // Full-length restart shows the counter was cleared
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
